divider_target_tx: RTL

- Serial transmitter that loads a new 16-bit divide target into a downstream clock divider over its two-wire target_data/target_clock link.
- Accepts a word from the control logic via valid/ready, serialises it MSB first, then asserts a latch strobe so the divider commits the word.
- Runs in the system clock domain. Generates target_clock itself; target_clock is not a clock inside this block.

---
 rtl/divider_target_tx.sv | 131 +++++++++++++
 1 files changed

// File: rtl/divider_target_tx.sv
// Serial loader for a downstream clock divider's target word: valid/ready in, MSB-first
// target_data/target_clock out, then a latch strobe. DIVIDER_TARGET_TX_PARITY_EN appends even parity.
module divider_target_tx #(
  parameter int WORD_WIDTH  = 16,
  parameter int HALF_PERIOD = 4,
  parameter int MIN_TARGET  = 2
) (
  input  logic                  system_clock,
  input  logic                  external_reset_n,
  input  logic                  load_valid,
  input  logic [WORD_WIDTH-1:0] load_target,
  output logic                  load_ready,
  output logic                  target_clock,
  output logic                  target_data,
  output logic                  target_latch,
  output logic                  busy,
  output logic                  done,
  output logic                  reject
);

`ifdef DIVIDER_TARGET_TX_PARITY_EN
  localparam int NBITS = WORD_WIDTH + 1;
`else
  localparam int NBITS = WORD_WIDTH;
`endif
  localparam int IW = $clog2(NBITS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  logic [1:0]       state;
  logic [7:0]       cnt;
  logic [NBITS-1:0] sreg;
  logic [IW-1:0]    idx;
  logic [NBITS-1:0] frame_word;
  logic             hp_end;

`ifdef DIVIDER_TARGET_TX_PARITY_EN
  assign frame_word = {load_target, ^load_target};
`else
  assign frame_word = load_target;
`endif

  assign hp_end = (cnt == HP_LAST);

  // Every output is a flop written together with the state it belongs to, so nothing glitches.
  always_ff @(posedge system_clock or negedge external_reset_n) begin
    if (!external_reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sreg         <= '0;
      idx          <= '0;
      load_ready   <= 1'b1;
      target_clock <= 1'b0;
      target_data  <= 1'b0;
      target_latch <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      reject       <= 1'b0;
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_valid) begin
            if (load_target < WORD_WIDTH'(MIN_TARGET)) begin
              reject <= 1'b1;
            end else begin
              state       <= S_SETUP;
              cnt         <= '0;
              sreg        <= frame_word;
              idx         <= IW'(NBITS - 1);
              busy        <= 1'b1;
              load_ready  <= 1'b0;
              target_data <= frame_word[NBITS-1];
            end
          end
        end
        S_SETUP: begin
          if (hp_end) begin
            state        <= S_HIGH;
            cnt          <= '0;
            target_clock <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_HIGH: begin
          if (hp_end) begin
            cnt          <= '0;
            target_clock <= 1'b0;
            if (idx == '0) begin
              state        <= S_LATCH;
              target_data  <= 1'b0;
              target_latch <= 1'b1;
            end else begin
              // Data moves on the falling edge so it is settled long before the next rise.
              state       <= S_SETUP;
              idx         <= idx - 1'b1;
              target_data <= sreg[idx - 1'b1];
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_LATCH: begin
          if (hp_end) begin
            state        <= S_IDLE;
            cnt          <= '0;
            sreg         <= '0;
            target_latch <= 1'b0;
            busy         <= 1'b0;
            load_ready   <= 1'b1;
            done         <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
